sync_ram_ctrl: RTL and testbench

//  Parametrised single-port synchronous RAM with a valid/ready request port,
//  a registered read-response path and a self-initialising sweep after reset.

---
 rtl/sync_ram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sync_ram_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: single-port synchronous RAM behind a valid/ready request port.
// After reset, a sweep writes every word. During the sweep req_ready is low.
// Read responses come from a register stage. With OUT_REG set, a second
// register stage is added.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (accept = valid & ready)
//   req_we, req_addr, req_wdata request kind, word address, write data
//   rsp_valid, rsp_rdata       one-cycle read response pulse, data (held when idle)
//   rsp_err                    read address was >= DEPTH (data forced to 0)
//   init_done                  sweep complete, sticky until reset
module sync_ram_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned INIT_MODE = 1,
  parameter int unsigned OUT_REG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              init_done_q, init_done_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              addr_ok;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] init_val;

  assign accept   = req_valid & req_ready_q;
  assign addr_ok  = {1'b0, req_addr} < DepthL;
  assign rd_fire  = accept & ~req_we;
  assign init_val = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;

  // Sweep state: one word per cycle, then IDLE forever (until reset).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d     = StIdle;
          cnt_d       = '0;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
      end
      default: state_d = StInit;
    endcase
  end

  // Single write port shared between the sweep and accepted writes.
  // Out-of-range writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = init_val;
    end else if (accept && req_we && addr_ok) begin
      mem_we = 1'b1;
    end
  end

  // First response stage. Data only moves on a read, so it holds otherwise.
  always_comb begin
    s1_valid_d = rd_fire;
    s1_err_d   = rd_fire & ~addr_ok;
    s1_data_d  = s1_data_q;
    if (rd_fire) begin
      s1_data_d = addr_ok ? mem_q[req_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_data_q   <= s1_data_d;
    end
  end

  // Storage is deliberately not reset. Only the sweep gives it known contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_valid_q;
    logic              s2_err_q;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_data_d = s2_data_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_err   = s2_err_q;
    assign rsp_rdata = s2_data_q;
  end else begin : g_no_out_reg
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_err_q;
    assign rsp_rdata = s1_data_q;
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl. Three instances share one request stream:
//   a: DEPTH=64 INIT_MODE=1 OUT_REG=0
//   b: DEPTH=48 INIT_MODE=1 OUT_REG=1
//   c: DEPTH=64 INIT_MODE=0 OUT_REG=0
module tb_sync_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;

  logic       ready_a, ready_b, ready_c;
  logic       vld_a, vld_b, vld_c;
  logic [7:0] dat_a, dat_b, dat_c;
  logic       err_a, err_b, err_c;
  logic       done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .INIT_MODE(1), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld_a), .rsp_rdata(dat_a),
    .rsp_err(err_a), .init_done(done_a)
  );

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .INIT_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld_b), .rsp_rdata(dat_b),
    .rsp_err(err_b), .init_done(done_b)
  );

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .INIT_MODE(0), .OUT_REG(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_c), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld_c), .rsp_rdata(dat_c),
    .rsp_err(err_c), .init_done(done_c)
  );

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       err_b;
    logic [7:0] exp_c;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock edge. Samples and drives happen 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Count edges until each instance raises req_ready. Also record whether
  // any response appeared in the meantime.
  task automatic wait_ready(output int ra, output int rb, output int rc, output bit seen);
    ra = 0; rb = 0; rc = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      step();
      if (ready_a && ra == 0) ra = cyc;
      if (ready_b && rb == 0) rb = cyc;
      if (ready_c && rc == 0) rc = cyc;
      if (vld_a || vld_b || vld_c) seen = 1'b1;
    end
  endtask

  initial begin
    int  ra, rb, rc;
    bit  seen;

    //      we    addr   wdata   a      b      err_b c
    vecs[0]  = '{1'b0, 6'd0,  8'h00, 8'd0,  8'd0,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 6'd5,  8'h00, 8'd5,  8'd5,  1'b0, 8'h00};
    vecs[2]  = '{1'b0, 6'd63, 8'h00, 8'd63, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 6'd10, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 6'd10, 8'h00, 8'hA5, 8'hA5, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 6'd50, 8'h00, 8'd50, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 6'd50, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 6'd50, 8'h00, 8'hFF, 8'h00, 1'b1, 8'hFF};
    vecs[8]  = '{1'b0, 6'd2,  8'h00, 8'd2,  8'd2,  1'b0, 8'h00};
    vecs[9]  = '{1'b1, 6'd47, 8'h3C, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 6'd47, 8'h00, 8'h3C, 8'h3C, 1'b0, 8'h3C};
    vecs[11] = '{1'b0, 6'd48, 8'h00, 8'd48, 8'h00, 1'b1, 8'h00};

    rst_n     = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    idle();
    step();
    step();

    chk("reset ready_a", 32'(ready_a), 0);
    chk("reset done_a", 32'(done_a), 0);
    chk("reset vld_b", 32'(vld_b), 0);
    chk("reset rdata_b", 32'(dat_b), 0);
    chk("reset err_a", 32'(err_a), 0);

    // Release reset. During the sweep, issue writes to addr 2 and then
    // reads. All of them must be ignored.
    rst_n = 1'b1;
    ra = 0; rb = 0; rc = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (cyc >= 10 && cyc <= 40) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd2; req_wdata = 8'h77;
      end else if (cyc > 40 && cyc <= 45) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd0;
      end else begin
        idle();
      end
      step();
      if (ready_a && ra == 0) ra = cyc;
      if (ready_b && rb == 0) rb = cyc;
      if (ready_c && rc == 0) rc = cyc;
      if (vld_a || vld_b || vld_c) seen = 1'b1;
    end
    chk("init cycles a", 32'(ra), 64);
    chk("init cycles b", 32'(rb), 48);
    chk("init cycles c", 32'(rc), 64);
    chk("init_done a", 32'(done_a), 1);
    chk("init_done b", 32'(done_b), 1);
    chk("no rsp during init", 32'(seen), 0);

    // Stream reads of addresses 0..15, one per cycle. Instance b lags by one cycle.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(i);
      end else begin
        idle();
      end
      step();
      if (i < 16) begin
        chk($sformatf("stream vld_a %0d", i), 32'(vld_a), 1);
        chk($sformatf("stream dat_a %0d", i), 32'(dat_a), 32'(i));
        chk($sformatf("stream dat_c %0d", i), 32'(dat_c), 0);
      end else begin
        chk($sformatf("stream vld_a end %0d", i), 32'(vld_a), 0);
      end
      if (i >= 1 && i <= 16) begin
        chk($sformatf("stream vld_b %0d", i), 32'(vld_b), 1);
        chk($sformatf("stream dat_b %0d", i), 32'(dat_b), 32'(i - 1));
      end else begin
        chk($sformatf("stream vld_b idle %0d", i), 32'(vld_b), 0);
      end
    end

    // Write followed immediately by a read of the same address.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd20; req_wdata = 8'h5A;
    step();
    chk("wr no rsp a", 32'(vld_a), 0);
    req_we = 1'b0;
    step();
    idle();
    chk("rar vld_a", 32'(vld_a), 1);
    chk("rar dat_a", 32'(dat_a), 32'h5A);
    chk("rar vld_b early", 32'(vld_b), 0);
    step();
    chk("rar pulse a", 32'(vld_a), 0);
    chk("rar hold dat_a", 32'(dat_a), 32'h5A);
    chk("rar vld_b", 32'(vld_b), 1);
    chk("rar dat_b", 32'(dat_b), 32'h5A);
    step();
    chk("rar pulse b", 32'(vld_b), 0);

    // Table-driven single operations.
    for (int k = 0; k < 12; k++) begin
      req_valid = 1'b1;
      req_we    = vecs[k].we;
      req_addr  = vecs[k].addr;
      req_wdata = vecs[k].wdata;
      step();
      idle();
      chk($sformatf("v%0d vld_a", k), 32'(vld_a), 32'(!vecs[k].we));
      chk($sformatf("v%0d vld_c", k), 32'(vld_c), 32'(!vecs[k].we));
      if (!vecs[k].we) begin
        chk($sformatf("v%0d dat_a", k), 32'(dat_a), 32'(vecs[k].exp_a));
        chk($sformatf("v%0d err_a", k), 32'(err_a), 0);
        chk($sformatf("v%0d dat_c", k), 32'(dat_c), 32'(vecs[k].exp_c));
      end
      step();
      chk($sformatf("v%0d vld_a off", k), 32'(vld_a), 0);
      chk($sformatf("v%0d vld_b", k), 32'(vld_b), 32'(!vecs[k].we));
      if (!vecs[k].we) begin
        chk($sformatf("v%0d dat_b", k), 32'(dat_b), 32'(vecs[k].exp_b));
        chk($sformatf("v%0d err_b", k), 32'(err_b), 32'(vecs[k].err_b));
      end
      step();
      chk($sformatf("v%0d vld_b off", k), 32'(vld_b), 0);
      chk($sformatf("v%0d err_b off", k), 32'(err_b), 0);
    end

    // A read is accepted, then reset is asserted before b can respond.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
    step();
    rst_n = 1'b0;
    idle();
    step();
    chk("rst drop vld_a", 32'(vld_a), 0);
    chk("rst drop vld_b", 32'(vld_b), 0);
    chk("rst ready_a", 32'(ready_a), 0);
    chk("rst done_b", 32'(done_b), 0);

    // Reset again partway through the sweep. The sweep must restart from 0.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("mid-init ready_a", 32'(ready_a), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready(ra, rb, rc, seen);
    chk("re-init cycles a", 32'(ra), 64);
    chk("re-init cycles b", 32'(rb), 48);
    chk("re-init no rsp", 32'(seen), 0);

    // The sweep rewrote addr 10, so the earlier 0xA5 is gone.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd10;
    step();
    idle();
    chk("re-init dat_a", 32'(dat_a), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
